// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: default word width and responder FSM encoding.
package spi_slave_pkg;

   // Default bits per word; the paired spi_master uses the same value.
   localparam int unsigned DefDataWidth = 4;

   typedef enum logic {
      StIdle   = 1'b0,
      StActive = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus a history flop for edge detection on an async pin.
module spi_sync_edge (
   input  logic clk_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync2_q, hist_q;

   // Left unreset so a pin already low during reset never looks like a fresh edge afterwards.
   always_ff @(posedge clk_i) begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
   end

   assign level_o = sync2_q;
   assign rise_o  = sync2_q & ~hist_q;
   assign fall_o  = ~sync2_q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first: oversamples SCLK/CS/MOSI in the clk domain,
// receives one DATA_WIDTH-bit word per count wrap and shifts tx_data out on MISO.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SCLK,
   input  logic                  CS,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_sync1_q, mosi_sync2_q, mosi_align_q;

   spi_sync_edge u_sclk_sync (
      .clk_i   (clk),
      .d_i     (SCLK),
      .level_o (sclk_level),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge u_cs_sync (
      .clk_i   (clk),
      .d_i     (CS),
      .level_o (cs_level),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   // MOSI synchronizer with one extra stage so it lines up with the SCLK history flop.
   always_ff @(posedge clk) begin
      mosi_sync1_q <= MOSI;
      mosi_sync2_q <= mosi_sync1_q;
      mosi_align_q <= mosi_sync2_q;
   end

   spi_state_e            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  miso_q, miso_d;
   logic                  reload_q, reload_d;

   // Frame FSM: start on CS fall, sample on SCLK rise, drive on SCLK fall, end on CS rise.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      rx_data_d   = rx_data_q;
      miso_d      = miso_q;
      reload_d    = reload_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d  = StActive;
               tx_sr_d  = tx_data;
               miso_d   = tx_data[DATA_WIDTH-1];
               cnt_d    = '0;
               reload_d = 1'b0;
            end
         end
         StActive: begin
            if (sclk_rise) begin
               rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], mosi_align_q};
               if (cnt_q == LastBit) begin
                  rx_data_d  = rx_sr_d;
                  rx_valid_d = 1'b1;
                  cnt_d      = '0;
                  reload_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            if (sclk_fall) begin
               if (reload_q) begin
                  tx_sr_d  = tx_data;
                  miso_d   = tx_data[DATA_WIDTH-1];
                  reload_d = 1'b0;
               end else begin
                  tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                  miso_d  = tx_sr_q[DATA_WIDTH-2];
               end
            end
            // Uses cnt_d so a rise completing the word in this same cycle is not an abort.
            if (cs_rise) begin
               state_d = StIdle;
               miso_d  = 1'b0;
               if (cnt_d != '0) begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         miso_q      <= 1'b0;
         reload_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         miso_q      <= miso_d;
         reload_q    <= reload_d;
      end
   end

   // Levels are only observed for edges; kept visible for debug.
   logic unused_levels;
   assign unused_levels = sclk_level ^ cs_level;

   assign MISO      = miso_q;
   assign miso_oe   = (state_q == StActive);
   assign busy      = (state_q == StActive);
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a behavioural SPI master drives frames, expected
// received words / aborts are queued at issue time and a monitor checks DUT pulses.
module tb_spi_slave;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         sclk, cs, mosi;
   logic         miso, miso_oe, rx_valid, frame_err, busy;
   logic [W-1:0] tx_data, rx_data;
   logic [W-1:0] mi0, mi1;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_rx_q[$];
   int           exp_ferr = 0;

   always #5 clk = ~clk;

   spi_slave #(.DATA_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .SCLK      (sclk),
      .CS        (cs),
      .MOSI      (mosi),
      .MISO      (miso),
      .miso_oe   (miso_oe),
      .tx_data   (tx_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every rx_valid must match the oldest queued word; every frame_err must be expected.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'(rx_data), 32'hFFFF);
            else check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
         end
         if (frame_err) begin
            check("frame_err_expected", 32'(exp_ferr), 32'(exp_ferr > 0 ? exp_ferr : 1));
            if (exp_ferr > 0) exp_ferr--;
         end
      end
   end

   // Master model: mode 0, half-period 8 clk. Last word may be cut short to nbits.
   task automatic frame(input int nwords, input logic [W-1:0] mo0, input logic [W-1:0] mo1,
                        input logic [W-1:0] tx1, input int nbits,
                        output logic [W-1:0] r0, output logic [W-1:0] r1);
      logic [W-1:0] mw, rw;
      int nb;
      r0 = '0;
      r1 = '0;
      cs = 1'b0;
      wait_clks(8);
      check("busy_in_frame", 32'(busy), 32'd1);
      for (int w = 0; w < nwords; w++) begin
         mw = (w == 0) ? mo0 : mo1;
         nb = (w == nwords - 1) ? nbits : W;
         rw = '0;
         for (int b = 0; b < nb; b++) begin
            mosi = mw[W-1-b];
            wait_clks(8);
            sclk = 1'b1;
            rw[W-1-b] = miso;
            if (b == W - 1 && w + 1 < nwords) begin
               wait_clks(5);
               tx_data = tx1;
               wait_clks(3);
            end else begin
               wait_clks(8);
            end
            sclk = 1'b0;
         end
         if (w == 0) r0 = rw;
         else r1 = rw;
      end
      wait_clks(8);
      cs = 1'b1;
      wait_clks(8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cs = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      tx_data = '0;
      wait_clks(5);
      check("rst_miso", 32'(miso), 0);
      check("rst_miso_oe", 32'(miso_oe), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      wait_clks(5);

      // Single word
      tx_data = 4'h5;
      exp_rx_q.push_back(4'hA);
      frame(1, 4'hA, 4'h0, 4'h0, W, mi0, mi1);
      check("single_miso_word", 32'(mi0), 32'h5);
      check("single_busy_after", 32'(busy), 0);

      // Streaming two words under one CS
      tx_data = 4'h9;
      exp_rx_q.push_back(4'h3);
      exp_rx_q.push_back(4'hC);
      frame(2, 4'h3, 4'hC, 4'h6, W, mi0, mi1);
      check("stream_miso_word0", 32'(mi0), 32'h9);
      check("stream_miso_word1", 32'(mi1), 32'h6);

      // Abort after 2 bits
      tx_data = 4'h7;
      exp_ferr++;
      frame(1, 4'hB, 4'h0, 4'h0, 2, mi0, mi1);
      check("abort_rx_held", 32'(rx_data), 32'hC);
      check("abort_miso_oe", 32'(miso_oe), 0);
      check("abort_ferr_seen", 32'(exp_ferr), 0);

      // Reset mid-frame after one bit
      tx_data = 4'hA;
      cs = 1'b0;
      wait_clks(8);
      mosi = 1'b1;
      wait_clks(8);
      sclk = 1'b1;
      wait_clks(8);
      sclk = 1'b0;
      wait_clks(2);
      rst = 1'b1;
      wait_clks(1);
      check("midrst_miso", 32'(miso), 0);
      check("midrst_miso_oe", 32'(miso_oe), 0);
      check("midrst_rx_data", 32'(rx_data), 0);
      check("midrst_busy", 32'(busy), 0);
      rst = 1'b0;
      wait_clks(4);
      cs = 1'b1;
      wait_clks(10);
      check("midrst_no_resume", 32'(busy), 0);
      exp_rx_q.push_back(4'hF);
      frame(1, 4'hF, 4'h0, 4'h0, W, mi0, mi1);
      check("after_rst_rx", 32'(rx_data), 32'hF);
      check("after_rst_miso_word", 32'(mi0), 32'hA);

      // Idle noise: SCLK toggles with CS high
      for (int i = 0; i < 4; i++) begin
         mosi = ~mosi;
         sclk = 1'b1;
         wait_clks(8);
         sclk = 1'b0;
         wait_clks(8);
      end
      check("idle_miso", 32'(miso), 0);
      check("idle_miso_oe", 32'(miso_oe), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_rx_held", 32'(rx_data), 32'hF);

      wait_clks(4);
      check("rx_queue_drained", 32'(exp_rx_q.size()), 0);
      check("ferr_pending", 32'(exp_ferr), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
